// File: rtl/servant_sram_pkg.sv
// servant_sram_pkg: shared definitions for the servant SRAM arbiter slice.
//   sramState_t          - access sequencer states
//   AW_DEFAULT           - default SRAM byte-address width
//   WAIT_CYCLES_DEFAULT  - default strobe width in clocks
//   HOST / CPU           - requester port indices
package servant_sram_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } sramState_t;

  localparam int AW_DEFAULT          = 18;
  localparam int WAIT_CYCLES_DEFAULT = 2;

  localparam logic HOST = 1'b0;
  localparam logic CPU  = 1'b1;

endpackage

// File: rtl/servant_sram_grant.sv
// servant_sram_grant: combinational picker choosing which requester owns the
// next SRAM access.
//   hReq, cReq  in   host / CPU request levels
//   lastGrant   in   port granted most recently (round-robin builds only)
//   grant       out  chosen port index (HOST or CPU)
// SERVANT_SRAM_ARB_RR_EN defined: round-robin on simultaneous requests.
// Undefined: fixed priority, host first.
module servant_sram_grant
  import servant_sram_pkg::*;
(
  input  logic hReq,
  input  logic cReq,
`ifdef SERVANT_SRAM_ARB_RR_EN
  input  logic lastGrant,
`endif
  output logic grant
);

  always_comb begin
    grant = HOST;
`ifdef SERVANT_SRAM_ARB_RR_EN
    if (hReq && cReq) begin
      grant = (lastGrant == HOST) ? CPU : HOST;
    end else if (cReq) begin
      grant = CPU;
    end
`else
    if (!hReq && cReq) begin
      grant = CPU;
    end
`endif
  end

endmodule

// File: rtl/servant_sram_arb.sv
// servant_sram_arb: shares an external 8-bit asynchronous SRAM between the
// host bridge and the SERV CPU data port. Each access runs SETUP (1 clk),
// STROBE (WAIT_CYCLES clks) and HOLD (1 clk, ack pulse). All SRAM pins are
// registered.
//   wb_clk, wb_rst            clock, synchronous active-high reset
//   i_h_* / o_h_*             host request port (req, we, adr, dat, rdt, ack)
//   i_c_* / o_c_*             CPU request port, same meaning
//   o_sram_adr/csn/oen/wen    SRAM address and active-low controls
//   o_sram_dq_oe/dq_out       DQ drive enable and write data
//   i_sram_dq_in              DQ read data
// SERVANT_SRAM_ARB_RR_EN selects round-robin arbitration (default: host first).
module servant_sram_arb
  import servant_sram_pkg::*;
#(
  parameter int AW          = AW_DEFAULT,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
  input  logic          wb_clk,
  input  logic          wb_rst,
  input  logic          i_h_req,
  input  logic          i_h_we,
  input  logic [AW-1:0] i_h_adr,
  input  logic [7:0]    i_h_dat,
  output logic [7:0]    o_h_rdt,
  output logic          o_h_ack,
  input  logic          i_c_req,
  input  logic          i_c_we,
  input  logic [AW-1:0] i_c_adr,
  input  logic [7:0]    i_c_dat,
  output logic [7:0]    o_c_rdt,
  output logic          o_c_ack,
  output logic [AW-1:0] o_sram_adr,
  output logic          o_sram_csn,
  output logic          o_sram_oen,
  output logic          o_sram_wen,
  output logic          o_sram_dq_oe,
  output logic [7:0]    o_sram_dq_out,
  input  logic [7:0]    i_sram_dq_in
);

  sramState_t    state, stateNext;
  logic [3:0]    cnt, cntNext;
  logic          weReg, weNext;
  logic          grantee, granteeNext;
  logic          grant;
  logic [AW-1:0] adrNext;
  logic [7:0]    datNext;
  logic          csnNext, oenNext, wenNext, dqOeNext;
  logic          hAckNext, cAckNext;
  logic          rdCapture;

`ifdef SERVANT_SRAM_ARB_RR_EN
  logic lastGrant;

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      lastGrant <= CPU;
    end else if (state == IDLE && (i_h_req || i_c_req)) begin
      lastGrant <= grant;
    end
  end
`endif

  servant_sram_grant uGrant (
    .hReq      (i_h_req),
    .cReq      (i_c_req),
`ifdef SERVANT_SRAM_ARB_RR_EN
    .lastGrant (lastGrant),
`endif
    .grant     (grant)
  );

  // The pin registers double as the latched address/data, so pin values are
  // derived from the next state and next latched contents.
  always_comb begin
    stateNext   = state;
    cntNext     = cnt;
    weNext      = weReg;
    granteeNext = grantee;
    adrNext     = o_sram_adr;
    datNext     = o_sram_dq_out;
    case (state)
      IDLE: begin
        if (i_h_req || i_c_req) begin
          granteeNext = grant;
          weNext      = (grant == CPU) ? i_c_we  : i_h_we;
          adrNext     = (grant == CPU) ? i_c_adr : i_h_adr;
          datNext     = (grant == CPU) ? i_c_dat : i_h_dat;
          stateNext   = SETUP;
        end
      end
      SETUP: begin
        stateNext = STROBE;
        cntNext   = 4'(WAIT_CYCLES - 1);
      end
      STROBE: begin
        if (cnt == 4'd0) begin
          stateNext = HOLD;
        end else begin
          cntNext = cnt - 4'd1;
        end
      end
      HOLD: begin
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase

    csnNext   = (stateNext == IDLE);
    oenNext   = !(stateNext == STROBE && !weNext);
    wenNext   = !(stateNext == STROBE && weNext);
    dqOeNext  = weNext && (stateNext != IDLE);
    hAckNext  = (stateNext == HOLD) && (granteeNext == HOST);
    cAckNext  = (stateNext == HOLD) && (granteeNext == CPU);
    rdCapture = (state == STROBE) && (cnt == 4'd0) && !weReg;
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state         <= IDLE;
      cnt           <= '0;
      weReg         <= 1'b0;
      grantee       <= HOST;
      o_sram_adr    <= '0;
      o_sram_dq_out <= '0;
      o_sram_csn    <= 1'b1;
      o_sram_oen    <= 1'b1;
      o_sram_wen    <= 1'b1;
      o_sram_dq_oe  <= 1'b0;
      o_h_ack       <= 1'b0;
      o_c_ack       <= 1'b0;
      o_h_rdt       <= '0;
      o_c_rdt       <= '0;
    end else begin
      state         <= stateNext;
      cnt           <= cntNext;
      weReg         <= weNext;
      grantee       <= granteeNext;
      o_sram_adr    <= adrNext;
      o_sram_dq_out <= datNext;
      o_sram_csn    <= csnNext;
      o_sram_oen    <= oenNext;
      o_sram_wen    <= wenNext;
      o_sram_dq_oe  <= dqOeNext;
      o_h_ack       <= hAckNext;
      o_c_ack       <= cAckNext;
      if (rdCapture) begin
        if (grantee == HOST) begin
          o_h_rdt <= i_sram_dq_in;
        end else begin
          o_c_rdt <= i_sram_dq_in;
        end
      end
    end
  end

endmodule

// File: tb/tb_servant_sram_arb.sv
// tb_servant_sram_arb: directed bench for servant_sram_arb. Instance A uses
// WAIT_CYCLES=2, instance B uses WAIT_CYCLES=1; each has a small SRAM model.
module tb_servant_sram_arb;
  localparam int AW = 18;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // instance A
  logic          hReq, hWe, cReq, cWe;
  logic [AW-1:0] hAdr, cAdr;
  logic [7:0]    hDat, cDat, hRdt, cRdt;
  logic          hAck, cAck;
  logic [AW-1:0] sAdr;
  logic          sCsn, sOen, sWen, sDqOe;
  logic [7:0]    sDqOut, sDqIn;

  // instance B
  logic          bhReq, bhWe, bcReq, bcWe;
  logic [AW-1:0] bhAdr, bcAdr;
  logic [7:0]    bhDat, bcDat, bhRdt, bcRdt;
  logic          bhAck, bcAck;
  logic [AW-1:0] bAdr;
  logic          bCsn, bOen, bWen, bDqOe;
  logic [7:0]    bDqOut, bDqIn;

  logic [7:0] memA [256];
  logic [7:0] memB [256];
  logic       memInit = 1'b0;

  always @(posedge clk) begin
    if (!memInit) begin
      memA[16] <= 8'hC3;
      memInit  <= 1'b1;
    end
    if (!sCsn && !sWen) memA[sAdr[7:0]] <= sDqOut;
    if (!bCsn && !bWen) memB[bAdr[7:0]] <= bDqOut;
  end

  assign sDqIn = (!sCsn && !sOen) ? memA[sAdr[7:0]] : 8'h00;
  assign bDqIn = (!bCsn && !bOen) ? memB[bAdr[7:0]] : 8'h00;

  servant_sram_arb #(.AW(AW), .WAIT_CYCLES(2)) dutA (
    .wb_clk(clk), .wb_rst(rst),
    .i_h_req(hReq), .i_h_we(hWe), .i_h_adr(hAdr), .i_h_dat(hDat),
    .o_h_rdt(hRdt), .o_h_ack(hAck),
    .i_c_req(cReq), .i_c_we(cWe), .i_c_adr(cAdr), .i_c_dat(cDat),
    .o_c_rdt(cRdt), .o_c_ack(cAck),
    .o_sram_adr(sAdr), .o_sram_csn(sCsn), .o_sram_oen(sOen), .o_sram_wen(sWen),
    .o_sram_dq_oe(sDqOe), .o_sram_dq_out(sDqOut), .i_sram_dq_in(sDqIn)
  );

  servant_sram_arb #(.AW(AW), .WAIT_CYCLES(1)) dutB (
    .wb_clk(clk), .wb_rst(rst),
    .i_h_req(bhReq), .i_h_we(bhWe), .i_h_adr(bhAdr), .i_h_dat(bhDat),
    .o_h_rdt(bhRdt), .o_h_ack(bhAck),
    .i_c_req(bcReq), .i_c_we(bcWe), .i_c_adr(bcAdr), .i_c_dat(bcDat),
    .o_c_rdt(bcRdt), .o_c_ack(bcAck),
    .o_sram_adr(bAdr), .o_sram_csn(bCsn), .o_sram_oen(bOen), .o_sram_wen(bWen),
    .o_sram_dq_oe(bDqOe), .o_sram_dq_out(bDqOut), .i_sram_dq_in(bDqIn)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    checks++;
    if ({sCsn, sOen, sWen, sDqOe} !== 4'b1110) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 1110", {sCsn, sOen, sWen, sDqOe});
    end
    checks++;
    if (sAdr !== 18'h0 || sDqOut !== 8'h00) begin
      errors++;
      $display("FAIL reset_adr_dat: got adr=%h dat=%h want 0/0", sAdr, sDqOut);
    end
    checks++;
    if ({hAck, cAck} !== 2'b00 || hRdt !== 8'h00 || cRdt !== 8'h00) begin
      errors++;
      $display("FAIL reset_ports: got ack=%b hRdt=%h cRdt=%h want 00/00/00", {hAck, cAck}, hRdt, cRdt);
    end
    checks++;
    if ({bCsn, bOen, bWen, bDqOe, bhAck, bcAck} !== 6'b111000 || bAdr !== 18'h0) begin
      errors++;
      $display("FAIL reset_b: got %b adr=%h want 111000 adr=0", {bCsn, bOen, bWen, bDqOe, bhAck, bcAck}, bAdr);
    end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_host_write();
    int wenLow = 0, wenFirst = -1, ackCnt = 0, ackAt = -1, cAckCnt = 0;
    int badHeld = 0, badOe = 0, badOen = 0, badIdle = 0;
    hReq = 1'b1; hWe = 1'b1; hAdr = 18'h20123; hDat = 8'h5A;
    cyc();
    hReq = 1'b0; hWe = 1'b0; hAdr = '0; hDat = 8'h00;
    for (int k = 0; k < 6; k++) begin
      if (k <= 3) begin
        if (sAdr !== 18'h20123 || sDqOut !== 8'h5A) badHeld++;
        if (sDqOe !== 1'b1 || sCsn !== 1'b0) badOe++;
      end else begin
        if (sCsn !== 1'b1 || sDqOe !== 1'b0) badIdle++;
      end
      if (sWen === 1'b0) begin
        if (wenFirst < 0) wenFirst = k;
        wenLow++;
      end
      if (sOen !== 1'b1) badOen++;
      if (hAck === 1'b1) begin ackCnt++; ackAt = k; end
      if (cAck === 1'b1) cAckCnt++;
      cyc();
    end
    checks++;
    if (wenLow != 2 || wenFirst != 1) begin
      errors++;
      $display("FAIL wr_wen: got low=%0d first=%0d want 2/1", wenLow, wenFirst);
    end
    checks++;
    if (ackCnt != 1 || ackAt != 3) begin
      errors++;
      $display("FAIL wr_ack: got count=%0d at=%0d want 1/3", ackCnt, ackAt);
    end
    checks++;
    if (badHeld != 0 || badOe != 0) begin
      errors++;
      $display("FAIL wr_adr_dq: got badHeld=%0d badOe=%0d want 0/0", badHeld, badOe);
    end
    checks++;
    if (badOen != 0 || badIdle != 0 || cAckCnt != 0) begin
      errors++;
      $display("FAIL wr_other: got oen=%0d idle=%0d cAck=%0d want 0/0/0", badOen, badIdle, cAckCnt);
    end
    checks++;
    if (memA[8'h23] !== 8'h5A) begin
      errors++;
      $display("FAIL wr_mem: got %h want 5a", memA[8'h23]);
    end
  endtask

  task automatic test_host_read();
    int oenLow = 0, oenFirst = -1, ackCnt = 0, ackAt = -1, cAckCnt = 0, badDq = 0;
    logic [7:0] rdtAtAck = 8'h00, rdtBefore = 8'hFF;
    hReq = 1'b1; hWe = 1'b0; hAdr = 18'h00010;
    cyc();
    hReq = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (sOen === 1'b0) begin
        if (oenFirst < 0) oenFirst = k;
        oenLow++;
      end
      if (sDqOe !== 1'b0 || sWen !== 1'b1) badDq++;
      if (k == 2) rdtBefore = hRdt;
      if (hAck === 1'b1) begin ackCnt++; ackAt = k; rdtAtAck = hRdt; end
      if (cAck === 1'b1) cAckCnt++;
      cyc();
    end
    checks++;
    if (oenLow != 2 || oenFirst != 1) begin
      errors++;
      $display("FAIL rd_oen: got low=%0d first=%0d want 2/1", oenLow, oenFirst);
    end
    checks++;
    if (ackCnt != 1 || ackAt != 3 || rdtAtAck !== 8'hC3) begin
      errors++;
      $display("FAIL rd_ack: got count=%0d at=%0d rdt=%h want 1/3/c3", ackCnt, ackAt, rdtAtAck);
    end
    checks++;
    if (rdtBefore !== 8'h00 || hRdt !== 8'hC3) begin
      errors++;
      $display("FAIL rd_hold: got before=%h after=%h want 00/c3", rdtBefore, hRdt);
    end
    checks++;
    if (badDq != 0 || cAckCnt != 0 || cRdt !== 8'h00) begin
      errors++;
      $display("FAIL rd_other: got dq=%0d cAck=%0d cRdt=%h want 0/0/00", badDq, cAckCnt, cRdt);
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] ackMask = '0, csnMask = '0;
    int badAdr = 0;
    hReq = 1'b1; hWe = 1'b0; hAdr = 18'h00010;
    cyc();
    for (int k = 0; k < 11; k++) begin
      if (hAck === 1'b1) ackMask[k] = 1'b1;
      if (sCsn === 1'b1) csnMask[k] = 1'b1;
      if (k >= 1 && k <= 3 && sAdr !== 18'h00010) badAdr++;
      if (k == 1) hAdr = 18'h3FFFF;
      if (k == 3) hAdr = 18'h00010;
      if (k == 5) hReq = 1'b0;
      cyc();
    end
    checks++;
    if (ackMask !== 11'h108) begin
      errors++;
      $display("FAIL b2b_ack: got %b want %b", ackMask, 11'h108);
    end
    checks++;
    if (csnMask !== 11'h610) begin
      errors++;
      $display("FAIL b2b_csn: got %b want %b", csnMask, 11'h610);
    end
    checks++;
    if (badAdr != 0) begin
      errors++;
      $display("FAIL b2b_adr_latch: got %0d bad cycles want 0", badAdr);
    end
  endtask

  task automatic test_arbitration();
    logic [3:0] seqBits = '0;
    int nAck = 0, bothAck = 0;
    logic [3:0] seqWant;
`ifdef SERVANT_SRAM_ARB_RR_EN
    seqWant = 4'b0101;
`else
    seqWant = 4'b0000;
`endif
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    hReq = 1'b1; hWe = 1'b0; hAdr = 18'h00010;
    cReq = 1'b1; cWe = 1'b0; cAdr = 18'h00010;
    cyc();
    for (int k = 0; k < 20; k++) begin
      if (hAck === 1'b1 && cAck === 1'b1) bothAck++;
      if (hAck === 1'b1 || cAck === 1'b1) begin
        seqBits = {seqBits[2:0], cAck};
        nAck++;
      end
      if (k == 19) begin hReq = 1'b0; cReq = 1'b0; end
      cyc();
    end
    checks++;
    if (nAck != 4 || bothAck != 0) begin
      errors++;
      $display("FAIL arb_count: got acks=%0d both=%0d want 4/0", nAck, bothAck);
    end
    checks++;
    if (seqBits !== seqWant) begin
      errors++;
      $display("FAIL arb_order: got %b want %b", seqBits, seqWant);
    end
    checks++;
`ifdef SERVANT_SRAM_ARB_RR_EN
    if (cRdt !== 8'hC3) begin
      errors++;
      $display("FAIL arb_crdt: got %h want c3", cRdt);
    end
`else
    if (cRdt !== 8'h00) begin
      errors++;
      $display("FAIL arb_crdt: got %h want 00", cRdt);
    end
`endif
  endtask

  task automatic test_reset_mid();
    int lateAck = 0, hAckCnt = 0;
    logic [5:0] ackMask = '0;
    logic [7:0] rdtAtAck = 8'h00;
    hReq = 1'b1; hWe = 1'b1; hAdr = 18'h00055; hDat = 8'h77;
    cyc();
    hReq = 1'b0;
    cyc();
    checks++;
    if (sWen !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_strobe: got wen=%b want 0", sWen);
    end
    rst = 1'b1;
    cyc();
    checks++;
    if ({sCsn, sOen, sWen, sDqOe, hAck} !== 5'b11100 || sAdr !== 18'h0 || sDqOut !== 8'h00) begin
      errors++;
      $display("FAIL rstmid_pins: got %b adr=%h dat=%h want 11100/0/00", {sCsn, sOen, sWen, sDqOe, hAck}, sAdr, sDqOut);
    end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (hAck === 1'b1 || cAck === 1'b1) lateAck++;
      cyc();
    end
    checks++;
    if (lateAck != 0) begin
      errors++;
      $display("FAIL rstmid_noack: got %0d acks want 0", lateAck);
    end
    cReq = 1'b1; cWe = 1'b0; cAdr = 18'h00010;
    cyc();
    cReq = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (cAck === 1'b1) begin ackMask[k] = 1'b1; rdtAtAck = cRdt; end
      if (hAck === 1'b1) hAckCnt++;
      cyc();
    end
    checks++;
    if (ackMask !== 6'b001000 || rdtAtAck !== 8'hC3 || hAckCnt != 0) begin
      errors++;
      $display("FAIL rstmid_cpu_read: got ack=%b rdt=%h hAck=%0d want 001000/c3/0", ackMask, rdtAtAck, hAckCnt);
    end
  endtask

  task automatic test_wait1();
    logic [4:0] wenMask = '0, oenMask = '0, ackMask = '0;
    logic [7:0] rdtAtAck = 8'h00;
    int hostAck = 0;
    bcReq = 1'b1; bcWe = 1'b1; bcAdr = 18'h00042; bcDat = 8'hA5;
    cyc();
    bcReq = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (bWen === 1'b0) wenMask[k] = 1'b1;
      if (bcAck === 1'b1) ackMask[k] = 1'b1;
      if (bhAck === 1'b1) hostAck++;
      cyc();
    end
    checks++;
    if (wenMask !== 5'b00010 || ackMask !== 5'b00100) begin
      errors++;
      $display("FAIL w1_write: got wen=%b ack=%b want 00010/00100", wenMask, ackMask);
    end
    ackMask = '0;
    bcReq = 1'b1; bcWe = 1'b0; bcAdr = 18'h00042;
    cyc();
    bcReq = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (bOen === 1'b0) oenMask[k] = 1'b1;
      if (bcAck === 1'b1) begin ackMask[k] = 1'b1; rdtAtAck = bcRdt; end
      if (bhAck === 1'b1) hostAck++;
      cyc();
    end
    checks++;
    if (oenMask !== 5'b00010 || ackMask !== 5'b00100) begin
      errors++;
      $display("FAIL w1_read_timing: got oen=%b ack=%b want 00010/00100", oenMask, ackMask);
    end
    checks++;
    if (rdtAtAck !== 8'hA5 || hostAck != 0) begin
      errors++;
      $display("FAIL w1_read_data: got rdt=%h hostAck=%0d want a5/0", rdtAtAck, hostAck);
    end
  endtask

  initial begin
    rst = 1'b1;
    hReq = 1'b0; hWe = 1'b0; hAdr = '0; hDat = 8'h00;
    cReq = 1'b0; cWe = 1'b0; cAdr = '0; cDat = 8'h00;
    bhReq = 1'b0; bhWe = 1'b0; bhAdr = '0; bhDat = 8'h00;
    bcReq = 1'b0; bcWe = 1'b0; bcAdr = '0; bcDat = 8'h00;
    test_reset();
    test_host_write();
    test_host_read();
    test_back_to_back();
    test_arbitration();
    test_reset_mid();
    test_wait1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
